// File: rtl/dmem_pkg.sv
// Shared types and constants for the data memory load/store unit.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_e;

    localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store mask/replication, load lane select with
// sign/zero extension, and natural-alignment checking.
module dmem_lane_align (
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_offset,
    input  logic        i_unsigned,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_read_word,
    output logic [3:0]  o_wmask,
    output logic [31:0] o_store_word,
    output logic [31:0] o_load_data,
    output logic        o_misalign
);
    import dmem_pkg::*;

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_read_word[{i_offset, 3'b000} +: 8];
    assign w_half = i_offset[1] ? i_read_word[31:16] : i_read_word[15:0];

    always_comb begin
        o_wmask      = 4'b0000;
        o_store_word = i_store_data;
        o_load_data  = 32'h0;
        o_misalign   = 1'b0;
        case (size_e'(i_size))
            SZ_BYTE: begin
                o_wmask      = 4'b0001 << i_offset;
                o_store_word = {4{i_store_data[7:0]}};
                o_load_data  = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
            end
            SZ_HALF: begin
                o_wmask      = i_offset[1] ? 4'b1100 : 4'b0011;
                o_store_word = {2{i_store_data[15:0]}};
                o_load_data  = {{16{w_half[15] & ~i_unsigned}}, w_half};
                o_misalign   = i_offset[0];
            end
            SZ_WORD: begin
                o_wmask      = 4'b1111;
                o_load_data  = i_read_word;
                o_misalign   = |i_offset;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_memory_lsu.sv
// Byte-addressed data memory with valid/ready request handshake and wait states.
// Define DMEM_ACCESS_COUNT_EN to add RD_COUNT/WR_COUNT/ERR_COUNT access counters.
module data_memory_lsu #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASEADDRESS = 32'h0000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_WE,
    input  logic [1:0]  REQ_SIZE,
    input  logic        REQ_UNSIGNED,
    input  logic [31:0] ADDR,
    input  logic [31:0] DATA_I,
    output logic        RSP_VALID,
    output logic        RSP_ERR,
    output logic [31:0] DATA_O
`ifdef DMEM_ACCESS_COUNT_EN
    ,
    output logic [31:0] RD_COUNT,
    output logic [31:0] WR_COUNT,
    output logic [31:0] ERR_COUNT
`endif
);
    import dmem_pkg::*;

    localparam int                    IDX_W       = $clog2(DEPTH_WORDS);
    localparam logic [32:0]           LP_LIMIT    = {1'b0, BASEADDRESS} + 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [WAIT_CNT_W-1:0] LP_CNT_INIT = WAIT_CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    logic [31:0]           r_mem [DEPTH_WORDS];
    state_e                r_state;
    state_e                w_state_next;
    logic [WAIT_CNT_W-1:0] r_cnt;
    logic                  r_ready;
    logic                  r_rsp_valid;
    logic                  r_rsp_err;
    logic [31:0]           r_data_o;
    logic [31:0]           r_hold_data;
    logic                  r_hold_err;

    logic                  w_accept;
    logic                  w_in_range;
    logic                  w_err;
    logic [31:0]           w_rel;
    logic [IDX_W-1:0]      w_index;
    logic [31:0]           w_read_word;
    logic [3:0]            w_wmask;
    logic [31:0]           w_store_word;
    logic [31:0]           w_load_data;
    logic [31:0]           w_rsp_data;
    logic                  w_misalign;
    logic                  w_unused;

    assign w_accept    = REQ_VALID && r_ready;
    // 33-bit compare keeps the upper bound from wrapping near the top of memory.
    assign w_in_range  = ({1'b0, ADDR} >= {1'b0, BASEADDRESS}) && ({1'b0, ADDR} < LP_LIMIT);
    assign w_rel       = ADDR - BASEADDRESS;
    assign w_index     = w_rel[IDX_W+1:2];
    assign w_unused    = ^{w_rel[31:IDX_W+2], w_rel[1:0]};
    assign w_read_word = r_mem[w_index];
    assign w_err       = !w_in_range || (REQ_SIZE == 2'b11) || w_misalign;
    assign w_rsp_data  = (w_err || REQ_WE) ? 32'h0 : w_load_data;

    dmem_lane_align u_align (
        .i_size       (REQ_SIZE),
        .i_offset     (ADDR[1:0]),
        .i_unsigned   (REQ_UNSIGNED),
        .i_store_data (DATA_I),
        .i_read_word  (w_read_word),
        .o_wmask      (w_wmask),
        .o_store_word (w_store_word),
        .o_load_data  (w_load_data),
        .o_misalign   (w_misalign)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = (WAIT_STATES > 0) ? WAIT : RESP;
            WAIT:    if (r_cnt == '0) w_state_next = RESP;
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_ready     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_data_o    <= 32'h0;
        end else begin
            r_state     <= w_state_next;
            r_ready     <= (w_state_next == IDLE);
            r_rsp_valid <= (w_state_next == RESP);
            if (w_accept) begin
                r_cnt <= LP_CNT_INIT;
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_state_next == RESP) begin
                r_rsp_err <= (r_state == IDLE) ? w_err : r_hold_err;
                r_data_o  <= (r_state == IDLE) ? w_rsp_data : r_hold_data;
            end else begin
                r_rsp_err <= 1'b0;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (w_accept) begin
            r_hold_data <= w_rsp_data;
            r_hold_err  <= w_err;
        end
    end

    always_ff @(posedge ACLK) begin
        if (w_accept && REQ_WE && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (w_wmask[b]) r_mem[w_index][8*b +: 8] <= w_store_word[8*b +: 8];
            end
        end
    end

`ifdef DMEM_ACCESS_COUNT_EN
    logic [31:0] r_rd_cnt;
    logic [31:0] r_wr_cnt;
    logic [31:0] r_err_cnt;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_rd_cnt  <= 32'h0;
            r_wr_cnt  <= 32'h0;
            r_err_cnt <= 32'h0;
        end else if (w_accept) begin
            if (w_err)       r_err_cnt <= r_err_cnt + 32'd1;
            else if (REQ_WE) r_wr_cnt  <= r_wr_cnt + 32'd1;
            else             r_rd_cnt  <= r_rd_cnt + 32'd1;
        end
    end

    assign RD_COUNT  = r_rd_cnt;
    assign WR_COUNT  = r_wr_cnt;
    assign ERR_COUNT = r_err_cnt;
`endif

    assign REQ_READY = r_ready;
    assign RSP_VALID = r_rsp_valid;
    assign RSP_ERR   = r_rsp_err;
    assign DATA_O    = r_data_o;

endmodule
